// File: rtl/instr_fetch.sv
// instr_fetch: owns the PC, issues word fetches to imem over valid/ready
// and buffers returned words in an in-order queue presented to decode.
// Ports: clk/rst_n; imem_req_{valid,ready}, imem_addr (request channel);
// imem_rsp_{valid,data} (in-order returns); redirect_{valid,pc} (flush);
// if_{valid,ready,instr,pc,pc_plus4} (decode side); redirect_misaligned.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        redirect_misaligned
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_rsp_pc;
  logic [31:0]   r_q_instr [DEPTH];
  logic [31:0]   r_q_pc    [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outst;
  logic [CW-1:0] r_discard;
  logic          r_run;
  logic          r_mis;

  logic [CW:0]   w_inflight;
  logic          w_req_valid;
  logic          w_acc;
  logic          w_rsp;
  logic          w_drop;
  logic          w_push;
  logic          w_if_valid;
  logic          w_pop;
  logic [31:0]   w_tgt;
  logic [31:0]   w_head_pc;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Words queued plus words still owed by memory: the credit pool.
  assign w_inflight = {1'b0, r_count} + {1'b0, r_outst};

  // r_run holds requests off for the first cycle after reset release.
  assign w_req_valid = r_run && !redirect_valid &&
                       (w_inflight < (CW+1)'(DEPTH));
  assign w_acc      = w_req_valid && imem_req_ready;
  // A return with nothing outstanding is a protocol error: ignore it.
  assign w_rsp      = imem_rsp_valid && (r_outst != '0);
  assign w_drop     = w_rsp && (r_discard != '0);
  assign w_push     = w_rsp && !w_drop && !redirect_valid;
  assign w_if_valid = (r_count != '0);
  assign w_pop      = w_if_valid && if_ready && !redirect_valid;
  assign w_tgt      = {redirect_pc[31:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_outst    <= '0;
      r_discard  <= '0;
      r_run      <= 1'b0;
      r_mis      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_q_instr[i] <= '0;
        r_q_pc[i]    <= '0;
      end
    end else begin
      r_run <= 1'b1;
      if (redirect_valid) begin
        r_fetch_pc <= w_tgt;
        r_rsp_pc   <= w_tgt;
        r_mis      <= |redirect_pc[1:0];
        r_count    <= '0;
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
        // Everything still in flight becomes stale; a return
        // landing this cycle is dropped here and not counted.
        r_outst    <= r_outst + CW'(w_acc) - CW'(w_rsp);
        r_discard  <= r_outst + CW'(w_acc) - CW'(w_rsp);
      end else begin
        if (w_acc) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        r_outst <= r_outst + CW'(w_acc) - CW'(w_rsp);
        if (w_drop) begin
          r_discard <= r_discard - CW'(1);
        end
        if (w_push) begin
          r_q_instr[r_wr_ptr] <= imem_rsp_data;
          r_q_pc[r_wr_ptr]    <= r_rsp_pc;
          r_wr_ptr            <= ptr_inc(r_wr_ptr);
          r_rsp_pc            <= r_rsp_pc + 32'd4;
        end
        if (w_pop) begin
          r_rd_ptr <= ptr_inc(r_rd_ptr);
        end
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  assign w_head_pc = w_if_valid ? r_q_pc[r_rd_ptr] : '0;

  assign imem_req_valid      = w_req_valid;
  assign imem_addr           = r_fetch_pc;
  assign if_valid            = w_if_valid;
  assign if_instr            = w_if_valid ? r_q_instr[r_rd_ptr] : '0;
  assign if_pc               = w_head_pc;
  assign if_pc_plus4         = w_if_valid ? w_head_pc + 32'd4 : '0;
  assign redirect_misaligned = r_mis;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed phases with randomized handshakes, checked
// against a queue-level model of fetch stream, memory and decode buffer.
module tb_instr_fetch;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        redirect_misaligned;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .imem_req_valid      (imem_req_valid),
    .imem_req_ready      (imem_req_ready),
    .imem_addr           (imem_addr),
    .imem_rsp_valid      (imem_rsp_valid),
    .imem_rsp_data       (imem_rsp_data),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .if_valid            (if_valid),
    .if_ready            (if_ready),
    .if_instr            (if_instr),
    .if_pc               (if_pc),
    .if_pc_plus4         (if_pc_plus4),
    .redirect_misaligned (redirect_misaligned)
  );

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  req_t        pend[$];
  ent_t        held[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          epoch = 0;
  logic [31:0] nf;
  bit          started;
  bit          exp_mis;
  int          lat_lo = 1;
  int          lat_hi = 1;
  int          p_ready = 100;
  int          p_ifr = 100;
  int          p_rsp = 100;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {~a[17:2], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag, input int n, input int lim);
    checks++;
    assert (n < lim) else begin
      errors++;
      $error("FAIL %s: waited %0d cycles, limit %0d", tag, n, lim);
    end
  endtask

  task automatic idle();
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if_ready       = 1'b0;
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic step(input bit redir, input logic [31:0] rpc);
    bit   rsp;
    bit   acc;
    bit   pop;
    bit   exp_req;
    req_t r;
    ent_t e;
    rsp = pend.size() > 0 && pend[0].due <= cyc &&
          ($urandom_range(99) < p_rsp);
    imem_req_ready = ($urandom_range(99) < p_ready);
    if_ready       = ($urandom_range(99) < p_ifr);
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem(pend[0].addr) : $urandom;
    #1;
    exp_req = started && !redir &&
              (held.size() + pend.size() < DEPTH);
    chk("req_valid", imem_req_valid, exp_req);
    chk("imem_addr", imem_addr, nf);
    chk("if_valid", if_valid, held.size() != 0);
    if (held.size() != 0) begin
      chk("if_instr", if_instr, held[0].instr);
      chk("if_pc", if_pc, held[0].pc);
      chk("if_pc_plus4", if_pc_plus4, held[0].pc + 32'd4);
    end
    chk("misaligned", redirect_misaligned, exp_mis);
    acc = exp_req && imem_req_ready;
    pop = held.size() != 0 && if_ready;
    if (rsp) r = pend.pop_front();
    if (redir) begin
      held.delete();
      epoch++;
      nf      = {rpc[31:2], 2'b00};
      exp_mis = |rpc[1:0];
    end else begin
      if (pop) e = held.pop_front();
      if (rsp && r.epoch == epoch) begin
        e.instr = mem(r.addr);
        e.pc    = r.addr;
        held.push_back(e);
      end
    end
    if (acc) begin
      r.addr  = nf;
      r.epoch = epoch;
      r.due   = cyc + $urandom_range(lat_hi, lat_lo);
      pend.push_back(r);
      nf += 32'd4;
    end
    @(posedge clk);
    started = 1'b1;
    cyc++;
    @(negedge clk);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_req_valid"}, imem_req_valid, 1'b0);
    chk({tag, "_addr"}, imem_addr, RESET_PC);
    chk({tag, "_if_valid"}, if_valid, 1'b0);
    chk({tag, "_if_instr"}, if_instr, 32'h0);
    chk({tag, "_if_pc"}, if_pc, 32'h0);
    chk({tag, "_if_pc_plus4"}, if_pc_plus4, 32'h0);
    chk({tag, "_misaligned"}, redirect_misaligned, 1'b0);
  endtask

  initial begin
    int          n;
    logic [31:0] rpc;
    idle();
    nf      = RESET_PC;
    started = 1'b0;
    exp_mis = 1'b0;
    #2;
    reset_checks("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming with a 1-cycle memory and decode always ready.
    repeat (20) step(1'b0, '0);

    // Decode stalls: buffer fills to DEPTH and requests stop.
    p_ifr = 0;
    repeat (8) step(1'b0, '0);
    chk("stall_if_valid", if_valid, 1'b1);
    chk("stall_req_off", imem_req_valid, 1'b0);
    p_ifr = 100;
    repeat (6) step(1'b0, '0);

    // Memory not ready: address holds at 0x8.
    step(1'b1, 32'h8);
    p_ready = 0;
    repeat (3) step(1'b0, '0);
    chk("hold_addr", imem_addr, 32'h8);
    p_ready = 100;
    repeat (6) step(1'b0, '0);

    // Redirect with two fetches in flight at 3-cycle latency.
    lat_lo = 3;
    lat_hi = 3;
    n = 0;
    while (pend.size() != 2 && n < 20) begin
      step(1'b0, '0);
      n++;
    end
    timeout("inflight2", n, 20);
    step(1'b1, 32'h100);
    n = 0;
    while (!if_valid && n < 20) begin
      step(1'b0, '0);
      n++;
    end
    timeout("redir_deliver", n, 20);
    chk("redir_pc", if_pc, 32'h100);
    chk("redir_pc4", if_pc_plus4, 32'h104);

    // Misaligned redirect target, then an aligned one.
    lat_lo = 1;
    lat_hi = 1;
    step(1'b1, 32'h102);
    chk("mis_set", redirect_misaligned, 1'b1);
    chk("mis_addr", imem_addr, 32'h100);
    repeat (5) step(1'b0, '0);
    step(1'b1, 32'h200);
    chk("mis_clr", redirect_misaligned, 1'b0);
    repeat (4) step(1'b0, '0);

    // Address wrap at the top of the 32-bit space.
    step(1'b1, 32'hFFFF_FFF8);
    n = 0;
    while (!(if_valid && if_pc == 32'hFFFF_FFFC) && n < 20) begin
      step(1'b0, '0);
      n++;
    end
    timeout("wrap_wait", n, 20);
    chk("wrap_pc4", if_pc_plus4, 32'h0);
    repeat (6) step(1'b0, '0);

    // Randomized handshakes, latencies and redirects.
    lat_lo  = 1;
    lat_hi  = 4;
    p_ready = 70;
    p_ifr   = 60;
    p_rsp   = 80;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) < 8) begin
        rpc = $urandom;
        if ($urandom_range(3) == 0) rpc[31:4] = '1;
        step(1'b1, rpc);
      end else begin
        step(1'b0, '0);
      end
    end

    // Redirect colliding with a pop and a response arrival.
    lat_lo  = 1;
    lat_hi  = 1;
    p_ready = 100;
    p_ifr   = 100;
    p_rsp   = 100;
    n = 0;
    while (!(held.size() > 0 && pend.size() > 0 &&
             pend[0].due <= cyc) && n < 30) begin
      step(1'b0, '0);
      n++;
    end
    timeout("collide_wait", n, 30);
    step(1'b1, 32'h400);
    chk("collide_if_valid", if_valid, 1'b0);
    chk("collide_addr", imem_addr, 32'h400);
    repeat (7) step(1'b0, '0);

    // Asynchronous reset in the middle of the stream.
    idle();
    #3;
    rst_n = 1'b0;
    #1;
    reset_checks("midreset");
    pend.delete();
    held.delete();
    nf      = RESET_PC;
    exp_mis = 1'b0;
    started = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) step(1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
